// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer: register offsets, CTRL/STATUS bit positions
// and the packed CTRL register layout.
package apb_timer_pkg;

  // Byte offsets of the registers within the APB window
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_PRE    = 8'h04;
  localparam logic [7:0] OFF_LOAD   = 8'h08;
  localparam logic [7:0] OFF_VALUE  = 8'h0C;
  localparam logic [7:0] OFF_STATUS = 8'h10;

  // CTRL bit positions
  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IRQEN    = 2;

  // STATUS bit positions
  localparam int STATUS_TOF = 0;

  // Word index of a byte offset, matching the PADDR[4:2] decode
  function automatic logic [2:0] regIndex(input logic [7:0] offset);
    return offset[4:2];
  endfunction

  localparam logic [2:0] IDX_CTRL   = regIndex(OFF_CTRL);
  localparam logic [2:0] IDX_PRE    = regIndex(OFF_PRE);
  localparam logic [2:0] IDX_LOAD   = regIndex(OFF_LOAD);
  localparam logic [2:0] IDX_VALUE  = regIndex(OFF_VALUE);
  localparam logic [2:0] IDX_STATUS = regIndex(OFF_STATUS);

  // CTRL register contents; en sits in bit 0 when packed
  typedef struct packed {
    logic irqEn;
    logic periodic;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/apb_timer_if.sv
// APB slave bus bundle for the timer; clock and reset stay plain ports.
interface apb_timer_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_timer_prescaler.sv
// Down-counting prescaler: emits one tick every pre+1 enabled cycles.
// A reload restarts the period from pre and suppresses any tick in that cycle,
// so a LOAD write never races a counter decrement.
module apb_timer_prescaler #(
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             reload,
  input  logic [PRE_W-1:0] pre,
  output logic             tick
);

  logic [PRE_W-1:0] count_q, count_d;

  assign tick = enable & ~reload & (count_q == '0);

  // Next count: reload has priority, otherwise count down and wrap to pre
  always_comb begin
    count_d = count_q;
    if (reload) begin
      count_d = pre;
    end else if (enable) begin
      if (count_q == '0) begin
        count_d = pre;
      end else begin
        count_d = count_q - PRE_W'(1);
      end
    end
  end

  // Prescaler state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/apb_timer.sv
// APB timer: prescaled 32-bit down counter with one-shot/periodic modes,
// sticky write-1-to-clear timeout flag and a level interrupt.
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int PRE_W = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  apb_timer_if.slave  apb,
  output logic        IRQ
);

  ctrl_t            ctrl_q, ctrl_d;
  logic [PRE_W-1:0] pre_q;
  logic [31:0]      load_q;
  logic [31:0]      value_q, value_d;
  logic             tof_q, tof_d;

  logic [2:0]       regIdx;
  logic             wrEn, wrCtrl, wrPre, wrLoad, wrStatus;
  logic             tick, pscReload, expire;
  logic [31:0]      rdData;
  logic             unusedAddr;

  assign regIdx   = apb.PADDR[4:2];
  assign wrEn     = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign wrCtrl   = wrEn & (regIdx == IDX_CTRL);
  assign wrPre    = wrEn & (regIdx == IDX_PRE);
  assign wrLoad   = wrEn & (regIdx == IDX_LOAD);
  assign wrStatus = wrEn & (regIdx == IDX_STATUS);

  // The prescaler restarts on a LOAD write and on an EN 0->1 transition
  assign pscReload = wrLoad | (wrCtrl & apb.PWDATA[CTRL_EN] & ~ctrl_q.en);
  assign expire    = tick & (value_q == 32'd0);

  apb_timer_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .enable (ctrl_q.en),
    .reload (pscReload),
    .pre    (pre_q),
    .tick   (tick)
  );

  // Next-state for CTRL, VALUE and TOF; bus writes override hardware updates
  // except for TOF, where a timeout set beats a coincident clear
  always_comb begin
    ctrl_d = ctrl_q;
    if (expire && !ctrl_q.periodic) begin
      ctrl_d.en = 1'b0;
    end
    if (wrCtrl) begin
      ctrl_d.en       = apb.PWDATA[CTRL_EN];
      ctrl_d.periodic = apb.PWDATA[CTRL_PERIODIC];
      ctrl_d.irqEn    = apb.PWDATA[CTRL_IRQEN];
    end

    value_d = value_q;
    if (wrLoad) begin
      value_d = apb.PWDATA;
    end else if (expire) begin
      value_d = ctrl_q.periodic ? load_q : 32'd0;
    end else if (tick) begin
      value_d = value_q - 32'd1;
    end

    tof_d = tof_q;
    if (expire) begin
      tof_d = 1'b1;
    end else if (wrStatus && apb.PWDATA[STATUS_TOF]) begin
      tof_d = 1'b0;
    end
  end

  // Register file and counter state
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl_q  <= '0;
      pre_q   <= '0;
      load_q  <= '0;
      value_q <= '0;
      tof_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      value_q <= value_d;
      tof_q   <= tof_d;
      if (wrPre) begin
        pre_q <= apb.PWDATA[PRE_W-1:0];
      end
      if (wrLoad) begin
        load_q <= apb.PWDATA;
      end
    end
  end

  // Read mux; unmapped offsets and non-read cycles return 0
  always_comb begin
    rdData = '0;
    if (apb.PSEL && !apb.PWRITE) begin
      case (regIdx)
        IDX_CTRL: begin
          rdData[CTRL_EN]       = ctrl_q.en;
          rdData[CTRL_PERIODIC] = ctrl_q.periodic;
          rdData[CTRL_IRQEN]    = ctrl_q.irqEn;
        end
        IDX_PRE:    rdData[PRE_W-1:0]  = pre_q;
        IDX_LOAD:   rdData             = load_q;
        IDX_VALUE:  rdData             = value_q;
        IDX_STATUS: rdData[STATUS_TOF] = tof_q;
        default:    rdData             = '0;
      endcase
    end
  end

  assign apb.PRDATA = rdData;
  assign apb.PREADY = 1'b1;
  assign IRQ        = tof_q & ctrl_q.irqEn;

  assign unusedAddr = &{1'b0, apb.PADDR[31:5], apb.PADDR[1:0]};

endmodule

// File: tb/tb_apb_timer.sv
// Directed testbench for apb_timer with a rule-level reference model checked every cycle.
module tb_apb_timer;

  logic PCLK;
  logic PRESETn;
  logic IRQ;

  apb_timer_if bus ();

  apb_timer #(
    .PRE_W (16)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .apb     (bus),
    .IRQ     (IRQ)
  );

  int checks = 0;
  int errors = 0;
  logic checkEn = 1'b0;

  // Reference model state (register contents after the last clock edge)
  logic        mEn, mPer, mIrqEn, mTof;
  logic [15:0] mPre;
  logic [31:0] mLoad, mValue;
  int unsigned mElapsed;

  logic        mWr, mRestart, mTick, mExpire;
  logic [2:0]  mIdx;
  logic [31:0] expRd;

  // Free-running clock
  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  function automatic logic [31:0] modelRead(input logic [2:0] idx);
    case (idx)
      3'd0:    return {29'd0, mIrqEn, mPer, mEn};
      3'd1:    return {16'd0, mPre};
      3'd2:    return mLoad;
      3'd3:    return mValue;
      3'd4:    return {31'd0, mTof};
      default: return 32'd0;
    endcase
  endfunction

  // Ticks happen every PRE+1 enabled cycles counted from the last restart,
  // the first one PRE cycles after the restart
  always_comb begin
    mWr      = bus.PSEL & bus.PENABLE & bus.PWRITE;
    mIdx     = bus.PADDR[4:2];
    mRestart = mWr && ((mIdx == 3'd2) || ((mIdx == 3'd0) && bus.PWDATA[0] && !mEn));
    mTick    = mEn && !mRestart && (mElapsed >= 32'(mPre)) &&
               (((mElapsed - 32'(mPre)) % (32'(mPre) + 32'd1)) == 32'd0);
    mExpire  = mTick && (mValue == 32'd0);
    expRd    = (bus.PSEL && !bus.PWRITE) ? modelRead(mIdx) : 32'd0;
  end

  // Model update at each clock edge, cleared asynchronously by reset
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      mEn <= 1'b0; mPer <= 1'b0; mIrqEn <= 1'b0; mTof <= 1'b0;
      mPre <= '0; mLoad <= '0; mValue <= '0; mElapsed <= 0;
    end else begin
      if (mRestart)    mElapsed <= 0;
      else if (mEn)    mElapsed <= mElapsed + 1;
      if (mExpire && !mPer) mEn <= 1'b0;
      if (mWr && mIdx == 3'd0) begin
        mEn <= bus.PWDATA[0]; mPer <= bus.PWDATA[1]; mIrqEn <= bus.PWDATA[2];
      end
      if (mWr && mIdx == 3'd1) mPre <= bus.PWDATA[15:0];
      if (mWr && mIdx == 3'd2) begin
        mLoad <= bus.PWDATA; mValue <= bus.PWDATA;
      end else if (mExpire) begin
        mValue <= mPer ? mLoad : 32'd0;
      end else if (mTick) begin
        mValue <= mValue - 32'd1;
      end
      if (mExpire) mTof <= 1'b1;
      else if (mWr && mIdx == 3'd4 && bus.PWDATA[0]) mTof <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all DUT outputs against the model
  always @(negedge PCLK) begin
    if (checkEn) begin
      checkOutput("irq", {31'd0, IRQ}, {31'd0, mTof & mIrqEn});
      checkOutput("pready", {31'd0, bus.PREADY}, 32'd1);
      checkOutput("prdata", bus.PRDATA, expRd);
    end
  end

  // Idle bus: continuously read VALUE so every cycle exposes the count
  task automatic busIdle();
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = 32'h0C; bus.PWDATA = 32'd0;
  endtask

  // Two-phase APB write; returns just after the edge where it takes effect
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
    @(posedge PCLK); #2;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = addr; bus.PWDATA = data;
    @(posedge PCLK); #2;
    bus.PENABLE = 1'b1;
    @(posedge PCLK); #2;
    busIdle();
  endtask

  task automatic readCheck(input logic [31:0] addr, input logic [31:0] exp, input string name);
    @(posedge PCLK); #2;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = addr;
    @(negedge PCLK);
    checkOutput(name, bus.PRDATA, exp);
  endtask

  // Wait (bounded) until the model count reaches v
  task automatic waitValue(input logic [31:0] v, input int maxCycles);
    bit found = 1'b0;
    for (int i = 0; i < maxCycles && !found; i++) begin
      @(negedge PCLK);
      if (mValue == v) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL waitValue: count never reached %h within %0d cycles", v, maxCycles);
    end
  endtask

  // Safety net against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios
  initial begin
    PRESETn = 1'b0;
    busIdle();
    @(posedge PCLK); #2;
    checkEn = 1'b1;
    @(posedge PCLK); #2;
    PRESETn = 1'b1;

    $display("[TB] reset state");
    for (int a = 0; a < 8; a++) readCheck(32'(a * 4), 32'd0, "reset_read");
    @(negedge PCLK);
    checkOutput("reset_irq", {31'd0, IRQ}, 32'd0);
    checkOutput("reset_pready", {31'd0, bus.PREADY}, 32'd1);

    $display("[TB] ignored writes");
    applyStimulus(32'h14, 32'hFFFF_FFFF);
    applyStimulus(32'h0C, 32'h0000_1234);
    readCheck(32'h14, 32'd0, "unmapped_read");
    readCheck(32'h0C, 32'd0, "value_ro");

    $display("[TB] one-shot");
    applyStimulus(32'h04, 32'd0);
    applyStimulus(32'h08, 32'd3);
    applyStimulus(32'h00, 32'h5);
    for (int k = 0; k < 4; k++) begin
      @(negedge PCLK);
      checkOutput("oneshot_value", bus.PRDATA, 32'(3 - k));
    end
    @(negedge PCLK);
    checkOutput("oneshot_irq", {31'd0, IRQ}, 32'd1);
    readCheck(32'h00, 32'h4, "oneshot_ctrl");
    readCheck(32'h0C, 32'd0, "oneshot_hold");
    applyStimulus(32'h10, 32'd1);

    $display("[TB] periodic with prescaler");
    applyStimulus(32'h04, 32'd2);
    applyStimulus(32'h08, 32'd1);
    applyStimulus(32'h00, 32'h3);
    for (int k = 0; k < 12; k++) begin
      @(negedge PCLK);
      checkOutput("periodic_value", bus.PRDATA, ((k / 3) % 2 == 0) ? 32'd1 : 32'd0);
    end
    readCheck(32'h10, 32'd1, "periodic_tof");
    @(negedge PCLK);
    checkOutput("periodic_noirq", {31'd0, IRQ}, 32'd0);
    applyStimulus(32'h00, 32'h0);
    applyStimulus(32'h10, 32'd1);

    $display("[TB] W1C collision");
    applyStimulus(32'h04, 32'd0);
    applyStimulus(32'h08, 32'd2);
    applyStimulus(32'h00, 32'h5);
    applyStimulus(32'h10, 32'd1);
    readCheck(32'h10, 32'd1, "w1c_set_wins");
    applyStimulus(32'h10, 32'd1);
    @(negedge PCLK);
    checkOutput("w1c_irq_clear", {31'd0, IRQ}, 32'd0);

    $display("[TB] CTRL write vs auto-clear");
    applyStimulus(32'h08, 32'd2);
    applyStimulus(32'h00, 32'h1);
    applyStimulus(32'h00, 32'h1);
    bus.PADDR = 32'h00;
    @(negedge PCLK);
    checkOutput("ctrl_wins", bus.PRDATA, 32'h1);
    repeat (3) @(posedge PCLK);
    #2 busIdle();
    applyStimulus(32'h00, 32'h0);
    applyStimulus(32'h10, 32'd1);

    $display("[TB] LOAD while running");
    applyStimulus(32'h04, 32'd3);
    applyStimulus(32'h08, 32'd20);
    applyStimulus(32'h00, 32'h1);
    waitValue(32'd5, 200);
    applyStimulus(32'h08, 32'h10);
    for (int k = 0; k < 5; k++) begin
      @(negedge PCLK);
      checkOutput("reload_value", bus.PRDATA, (k < 4) ? 32'h10 : 32'h0F);
    end

    $display("[TB] mid-count reset");
    applyStimulus(32'h04, 32'd0);
    applyStimulus(32'h08, 32'd20);
    waitValue(32'd7, 100);
    #2 PRESETn = 1'b0;
    @(negedge PCLK); #2;
    PRESETn = 1'b1;
    for (int a = 0; a < 5; a++) readCheck(32'(a * 4), 32'd0, "post_reset_read");
    repeat (4) @(posedge PCLK);
    #2 busIdle();
    applyStimulus(32'h00, 32'h5);
    @(negedge PCLK);
    checkOutput("reenable_irq0", {31'd0, IRQ}, 32'd0);
    @(negedge PCLK);
    checkOutput("reenable_irq1", {31'd0, IRQ}, 32'd1);

    repeat (2) @(posedge PCLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
